// File: rtl/dm_store_buffer.sv
// dm_store_buffer: small FIFO store buffer in front of a 1024x32 word-addressed
// data memory (async read, single sync write port, no byte enables).
// Stores from MEM are queued with byte enables and drained one per cycle.
// Partial stores use read-merge-write against dm_dout. Loads own the DM port
// and see per-byte forwarded data from pending stores.
//
// Optional feature macro: SB_COALESCE_EN
//   When defined, a store whose word matches the youngest entry is merged
//   into that entry (unless that entry is the head draining this cycle).
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   st_valid/st_ready  store handshake (st_ready combinational)
//   st_addr/data/be/pc store byte address, lane-aligned data, byte enables, PC
//   ld_req/ld_addr     load access this cycle and its byte address
//   ld_data            forwarded load word (combinational)
//   dm_addr/din/pc/we  DM port: address, merged write data, store PC, write enable
//   dm_dout            DM read data for dm_addr
//   sb_empty/sb_count  occupancy status
module dm_store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [3:0]       st_be,
    input  logic [31:0]      st_pc,
    input  logic             ld_req,
    input  logic [31:0]      ld_addr,
    output logic [31:0]      ld_data,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_din,
    output logic [31:0]      dm_pc,
    output logic             dm_we,
    input  logic [31:0]      dm_dout,
    output logic             sb_empty,
    output logic [CNT_W-1:0] sb_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WA_W  = 10;

    logic [WA_W-1:0]  ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [3:0]       ent_be   [DEPTH];
    logic [31:0]      ent_pc   [DEPTH];
    logic [DEPTH-1:0] ent_valid;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] fwd_idx;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             drain;
    logic             merge_hit;
    logic             push;
    logic [31:0]      head_mask;

    // Address bits outside the 1024-word window are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{st_addr[31:12], st_addr[1:0], ld_addr[31:12], ld_addr[1:0]};

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    assign full  = (count == CNT_W'(DEPTH));
    // A store in the reset cycle must never reach DM, so reset blocks draining.
    assign drain = !reset && !ld_req && (count != '0);

`ifdef SB_COALESCE_EN
    logic [PTR_W-1:0] youngest;
    logic             merge;
    assign youngest  = tail - PTR_W'(1);
    // Merging into the entry being written to DM this cycle would lose bytes.
    assign merge_hit = (count != '0) && ent_valid[youngest]
                     && (ent_addr[youngest] == st_addr[11:2])
                     && !(drain && (youngest == head));
    assign merge     = st_valid && st_ready && merge_hit;
`else
    assign merge_hit = 1'b0;
`endif

    assign st_ready = !reset && !ld_req && (!full || drain || merge_hit);
    assign push     = st_valid && st_ready && !merge_hit;

    // Pointers, count and valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (drain) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            if (push) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(drain);
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= st_addr[11:2];
            ent_data[tail] <= st_data;
            ent_be[tail]   <= st_be;
            ent_pc[tail]   <= st_pc;
        end
`ifdef SB_COALESCE_EN
        else if (merge) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) ent_data[youngest][8*i +: 8] <= st_data[8*i +: 8];
            end
            ent_be[youngest] <= ent_be[youngest] | st_be;
            ent_pc[youngest] <= st_pc;
        end
`endif
    end

    // Per-lane forwarding: walk oldest to youngest so the youngest match wins.
    always_comb begin
        ld_data = dm_dout;
        fwd_idx = head;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head + PTR_W'(k);
            if (ent_valid[fwd_idx] && (ent_addr[fwd_idx] == ld_addr[11:2])) begin
                for (int i = 0; i < 4; i++) begin
                    if (ent_be[fwd_idx][i]) ld_data[8*i +: 8] = ent_data[fwd_idx][8*i +: 8];
                end
            end
        end
    end

    // DM port: load has priority, otherwise drain the head entry.
    always_comb begin
        dm_addr   = '0;
        dm_din    = '0;
        dm_pc     = '0;
        dm_we     = 1'b0;
        head_mask = lane_mask(ent_be[head]);
        if (ld_req) begin
            dm_addr = {20'b0, ld_addr[11:2], 2'b00};
        end else if (drain) begin
            dm_addr = {20'b0, ent_addr[head], 2'b00};
            dm_din  = (ent_data[head] & head_mask) | (dm_dout & ~head_mask);
            dm_pc   = ent_pc[head];
            dm_we   = 1'b1;
        end
    end

    assign sb_empty = (count == '0);
    assign sb_count = count;

endmodule
